// File: rtl/rvfpm_xif_lsu_if.sv
// ---------------------------------------------------------------------------
// pa_rvfpm / rvfpm_xif_lsu_if
// Purpose : CORE-V-XIF memory channel payload types (pa_rvfpm) and the
//           interface bundling the memory request/result channel between the
//           rvfpm load/store unit (master) and the memory side (slave).
// Signals : mem_valid        request valid            (master -> slave)
//           mem_ready        request ready            (slave  -> master)
//           mem_req          request payload          (master -> slave)
//           mem_result_valid result valid             (slave  -> master)
//           mem_result       result payload           (slave  -> master)
// ---------------------------------------------------------------------------
package pa_rvfpm;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_MEM_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]    id;
    logic [31:0]              addr;
    logic [1:0]               mode;
    logic                     we;
    logic [2:0]               size;
    logic [X_MEM_WIDTH/8-1:0] be;
    logic [1:0]               attr;
    logic [X_MEM_WIDTH-1:0]   wdata;
    logic                     last;
    logic                     spec;
  } x_mem_req_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
    logic                   dbg;
  } x_mem_result_t;

endpackage

interface rvfpm_xif_lsu_if;
  import pa_rvfpm::*;

  logic          mem_valid;
  logic          mem_ready;
  x_mem_req_t    mem_req;
  logic          mem_result_valid;
  x_mem_result_t mem_result;

  modport master (
    output mem_valid,
    output mem_req,
    input  mem_ready,
    input  mem_result_valid,
    input  mem_result
  );

  modport slave (
    input  mem_valid,
    input  mem_req,
    output mem_ready,
    output mem_result_valid,
    output mem_result
  );

endinterface

// File: rtl/rvfpm_xif_lsu.sv
// ---------------------------------------------------------------------------
// rvfpm_xif_lsu
// Purpose : Memory stage of rvfpm. Executes single-precision FLW/FSW over the
//           CORE-V-XIF memory channel, one transaction outstanding, with a
//           per-request response timeout. Load data is written back to the FP
//           register file; every op (load or store) reports a completion with
//           an error flag (bus error, misaligned address, timeout).
// Ports   : clk, rst_n                clock, synchronous active-low reset
//           ls_valid_i / ls_ready_o   decoded op handshake
//           ls_id_i, ls_we_i          instruction id, 1=FSW 0=FLW
//           ls_addr_i, ls_rd_i        effective address, FLW destination
//           ls_wdata_i                FSW store data
//           mem_if (master)           XIF memory request/result channel
//           wb_valid_o/wb_rd_o/wb_data_o      FP regfile write (1-cycle strobe)
//           done_valid_o/done_id_o/done_err_o completion (1-cycle strobe)
// ---------------------------------------------------------------------------
module rvfpm_xif_lsu
  import pa_rvfpm::*;
#(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_MEM_WIDTH = 32,
  parameter int FLEN        = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ls_valid_i,
  output logic                  ls_ready_o,
  input  logic [X_ID_WIDTH-1:0] ls_id_i,
  input  logic                  ls_we_i,
  input  logic [31:0]           ls_addr_i,
  input  logic [4:0]            ls_rd_i,
  input  logic [FLEN-1:0]       ls_wdata_i,

  rvfpm_xif_lsu_if.master       mem_if,

  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [FLEN-1:0]       wb_data_o,

  output logic                  done_valid_o,
  output logic [X_ID_WIDTH-1:0] done_id_o,
  output logic                  done_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                state_q;
  logic                  ls_ready_q;
  logic                  mem_valid_q;
  x_mem_req_t            mem_req_q;
  x_mem_req_t            mem_req_d;
  logic                  wb_valid_q;
  logic [4:0]            wb_rd_q;
  logic [FLEN-1:0]       wb_data_q;
  logic                  done_valid_q;
  logic [X_ID_WIDTH-1:0] done_id_q;
  logic                  done_err_q;

  // Op context held for the life of the transaction.
  logic [X_ID_WIDTH-1:0] id_q;
  logic                  we_q;
  logic [4:0]            rd_q;

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  logic                  misaligned;
  logic                  result_hit;
  logic                  timeout_hit;
  logic                  unused_result_dbg;

  always_comb begin
    mem_req_d       = '0;
    mem_req_d.id    = ls_id_i;
    mem_req_d.addr  = ls_addr_i;
    mem_req_d.mode  = 2'b11;
    mem_req_d.we    = ls_we_i;
    mem_req_d.size  = 3'b010;
    mem_req_d.be    = '1;
    mem_req_d.attr  = 2'b00;
    mem_req_d.wdata = ls_we_i ? X_MEM_WIDTH'(ls_wdata_i) : '0;
    mem_req_d.last  = 1'b1;
    mem_req_d.spec  = 1'b0;

    cnt_d       = cnt_q + 1'b1;
    // cnt_q counts completed WAIT cycles, so hitting TIMEOUT on cnt_d means
    // this is the TIMEOUT-th WAIT cycle.
    timeout_hit = (cnt_d == CNT_W'(TIMEOUT));
    // Results tagged with another id belong to someone else; drop them.
    result_hit  = mem_if.mem_result_valid && (mem_if.mem_result.id == id_q);
    misaligned  = (ls_addr_i[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ls_ready_q   <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_req_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
      id_q         <= '0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ls_valid_i) begin
            id_q       <= ls_id_i;
            we_q       <= ls_we_i;
            rd_q       <= ls_rd_i;
            ls_ready_q <= 1'b0;
            if (misaligned) begin
              // Misaligned access never reaches the bus.
              state_q      <= S_RESP;
              done_valid_q <= 1'b1;
              done_id_q    <= ls_id_i;
              done_err_q   <= 1'b1;
              wb_rd_q      <= ls_rd_i;
            end else begin
              state_q     <= S_REQ;
              mem_valid_q <= 1'b1;
              mem_req_q   <= mem_req_d;
            end
          end
        end

        S_REQ: begin
          // Request stays up with a frozen payload until accepted.
          if (mem_if.mem_ready) begin
            mem_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A matching result takes priority over a same-cycle timeout.
          if (result_hit) begin
            state_q      <= S_RESP;
            done_valid_q <= 1'b1;
            done_id_q    <= id_q;
            done_err_q   <= mem_if.mem_result.err;
            wb_valid_q   <= !we_q && !mem_if.mem_result.err;
            wb_rd_q      <= rd_q;
            wb_data_q    <= mem_if.mem_result.rdata[FLEN-1:0];
          end else if (timeout_hit) begin
            state_q      <= S_RESP;
            done_valid_q <= 1'b1;
            done_id_q    <= id_q;
            done_err_q   <= 1'b1;
            wb_rd_q      <= rd_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RESP: begin
          state_q      <= S_IDLE;
          ls_ready_q   <= 1'b1;
          done_valid_q <= 1'b0;
          done_err_q   <= 1'b0;
          wb_valid_q   <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          ls_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign unused_result_dbg = mem_if.mem_result.dbg;

  assign ls_ready_o       = ls_ready_q;
  assign mem_if.mem_valid = mem_valid_q;
  assign mem_if.mem_req   = mem_req_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign done_valid_o     = done_valid_q;
  assign done_id_o        = done_id_q;
  assign done_err_o       = done_err_q;

endmodule
